mux_nto1_rr: RTL
================

Name: mux_nto1_rr

Overview:
- Parametrised, registered N-to-1 multiplexer; successor to the combinational 4:1 mux.
- Adds a W-bit data path and per-channel valid/ready handshakes.
- Two selection modes: direct (external SEL) and round-robin (internal fair pointer).
- Sits between several producer channels and one consumer. The output is registered, so it can feed downstream logic without a combinational path from the inputs.

Parameters:
- N, 4, number of input channels (2..16, need not be a power of two)
- W, 8, data width per channel in bits
- SW, 2, select/channel-id width; must equal clog2(N) (checked at elaboration)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset; asynchronous, active-high
- I  input  N*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W]
- I_VLD  input  N  per-channel valid
- I_RDY  output  N  per-channel ready; at most one bit high per cycle
- SEL  input  SW  channel select, used only when MODE=0
- MODE  input  1  0 = direct select, 1 = round-robin
- Y  output  W  registered output data
- Y_VLD  output  1  output register holds a valid word
- Y_RDY  input  1  consumer accepts Y this cycle
- Y_CH  output  SW  channel index that produced the current Y

Behaviour:
- Reset:
  - RST high asynchronously clears Y=0, Y_VLD=0, Y_CH=0 and the round-robin pointer PTR=0.
  - A word held at reset is dropped, not delivered.
  - I_RDY is all-zero while RST is high.
- Load enable: LD = !Y_VLD | Y_RDY. The output register may take a new word only when empty or being drained in the same cycle.
- Grant, combinational from the current inputs:
  - MODE=0: grant channel SEL if SEL<N and I_VLD[SEL]=1; otherwise no grant. SEL>=N never grants.
  - MODE=1: grant the first channel with I_VLD=1, searching PTR, PTR+1, ..., wrapping modulo N; no grant if all I_VLD=0.
- Handshake:
  - I_RDY[g] = LD & grant_valid for the granted channel g; all other I_RDY bits are 0.
  - A transfer on channel g occurs when I_VLD[g] & I_RDY[g].
- Rising edge with a transfer: Y <= I[g], Y_CH <= g, Y_VLD <= 1.
- Rising edge with LD=1 and no transfer: Y_VLD <= 0; Y and Y_CH hold their last value.
- Rising edge with LD=0: the register holds; Y, Y_CH and Y_VLD must stay stable while Y_VLD=1 & Y_RDY=0.
- Latency: 1 cycle from input transfer to Y_VLD. Sustained throughput: 1 word per cycle when Y_RDY is held high.
- Drain and refill: Y_RDY=1 and a new transfer in the same cycle replaces the word with no bubble.
- Pointer:
  - After each transfer in MODE=1, PTR <= (g+1) mod N, wrapping N-1 to 0 for non-power-of-two N.
  - PTR does not change in MODE=0 or without a transfer.
- Mode and select changes:
  - Take effect on the next grant decision.
  - Never alter a word already held in the output register.
  - PTR is retained across mode switches.
- Input rule: a producer must keep I_VLD and its data stable until accepted. The block does not check this.
- Data width rules: pure selection, no arithmetic on data. Y_CH is zero-extended to SW bits.

Decomposition:
- Package mux_pkg:
  - mode constants MODE_DIRECT=1'b0 and MODE_RR=1'b1
  - an elaboration-time clog2 helper used to check SW
- Sub-module rr_arbiter (parameter N, SW):
  - inputs: request vector, pointer, enable
  - outputs: one-hot grant, encoded index, grant_valid
  - purely combinational, instantiated once for MODE=1
- Top level holds the direct-select path, LD logic, the output register and PTR.

Test Plan:
All scenarios use N=4, W=8, with I = {8'hD3, 8'hC2, 8'hB1, 8'hA0} (channel 3 down to channel 0).
- Reset: assert RST mid-stream while Y_VLD=1 -> Y=8'h00, Y_VLD=0, Y_CH=0 immediately, before the next edge; I_RDY=4'b0000.
- Direct mode:
  - Setup: MODE=0, I_VLD=4'b1111, Y_RDY=1.
  - Stimulus: SEL steps 0,1,2,3, one per cycle.
  - Response: Y = A0, B1, C2, D3 one cycle after each step; Y_CH matches SEL; I_RDY one-hot on SEL.
- Round-robin fairness: MODE=1, I_VLD=4'b1111, Y_RDY=1 for 8 cycles -> Y_CH sequence 0,1,2,3,0,1,2,3 with Y_VLD continuously 1.
- Round-robin skip: MODE=1, I_VLD=4'b1010, PTR=0 -> grants 1,3,1,3; channels 0 and 2 never see I_RDY.
- Backpressure:
  - Setup: MODE=1, Y_VLD=1 holding B1 with Y_CH=1, I_VLD=4'b1111.
  - Stimulus: Y_RDY=0 for 3 cycles, then 1.
  - Response: Y holds B1 and I_RDY=0 during the stall; the cycle Y_RDY=1, I_RDY=4'b0100 and C2 appears on the next edge with no bubble.
- Out-of-range and idle:
  - Setup: MODE=0, SEL=2, I_VLD=4'b1011, Y_RDY=1.
  - Response: no grant and Y_VLD drops to 0 after the drain; Y holds its last value.
  - Then I_VLD=4'b0000 in MODE=1 -> PTR unchanged.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared mode constants and elaboration helpers for mux_nto1_rr
package mux_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          vld
);
  logic [SW-1:0] c;
  // first requester at or after ptr, wrapping modulo N
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    c   = '0;
    for (int i = 0; i < N; i++) begin
      c = SW'((int'(ptr) + i) % N);
      if (en && !vld && req[c]) begin
        vld    = 1'b1;
        idx    = c;
        gnt[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: registered N-to-1 mux with valid/ready, direct or round-robin select
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N*W-1:0] I,
  input  logic [N-1:0]   I_VLD,
  output logic [N-1:0]   I_RDY,
  input  logic [SW-1:0]  SEL,
  input  logic           MODE,
  output logic [W-1:0]   Y,
  output logic           Y_VLD,
  input  logic           Y_RDY,
  output logic [SW-1:0]  Y_CH
);
  if (SW != clog2(N)) begin : g_bad_sw
    $error("SW must equal clog2(N)");
  end
  logic [W-1:0]  ch [N];
  logic [SW-1:0] ptr;
  logic [N-1:0]  rr_gnt;
  logic [SW-1:0] rr_idx;
  logic          rr_vld;
  logic          ld;
  logic          d_vld;
  logic [SW-1:0] g;
  logic          gv;
  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch[k] = I[k*W +: W];
  end
  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req(I_VLD),
    .ptr(ptr),
    .en (MODE == MODE_RR),
    .gnt(rr_gnt),
    .idx(rr_idx),
    .vld(rr_vld)
  );
  // load when empty or draining; grant chosen by mode, direct SEL>=N never grants
  always_comb begin
    ld    = !Y_VLD || Y_RDY;
    d_vld = (MODE == MODE_DIRECT) && ({1'b0, SEL} < (SW+1)'(N)) && I_VLD[SEL];
    g     = (MODE == MODE_RR) ? rr_idx : SEL;
    gv    = (MODE == MODE_RR) ? rr_vld : d_vld;
    I_RDY = (RST || !ld) ? '0 : (MODE == MODE_RR) ? rr_gnt : d_vld ? N'(1) << SEL : '0;
  end
  // output register and fairness pointer; a transfer is ld with a grant
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Y     <= '0;
      Y_VLD <= 1'b0;
      Y_CH  <= '0;
      ptr   <= '0;
    end else if (ld) begin
      Y_VLD <= gv;
      if (gv) begin
        Y    <= ch[g];
        Y_CH <= g;
      end
      if (gv && MODE == MODE_RR) ptr <= (g == SW'(N-1)) ? '0 : g + 1'b1;
    end
  end
endmodule
